// File: rtl/rc4_mem_pkg.sv
// rtl/rc4_mem_pkg.sv - shared types and width helpers for the burst memory reader
package rc4_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int idx_width(input int dep);
        return (dep > 1) ? $clog2(dep) : 1;
    endfunction

    function automatic int len_width(input int dep);
        return $clog2(dep + 1);
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// rtl/rd_lat_pipe.sv - valid/index delay line that matches the memory read latency
module rd_lat_pipe #(
    parameter int LAT = 1,
    parameter int IW  = 5
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic          pending
);

    logic          valid_q [LAT];
    logic [IW-1:0] idx_q   [LAT];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < LAT; i++) begin
                valid_q[i] <= 1'b0;
                idx_q[i]   <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            idx_q[0]   <= in_idx;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    // Words still in flight behind the one being captured this cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            pending = pending | valid_q[i];
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_idx   = idx_q[LAT-1];

endmodule

// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - pipelined burst reader copying a memory window into a local buffer
module mem_burst_reader
    import rc4_mem_pkg::*;
#(
    parameter int DEP    = 32,
    parameter int WID    = 8,
    parameter int AW     = 9,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [AW-1:0]             base_addr,
    input  logic [len_width(DEP)-1:0] burst_len,
    input  logic                      abort,
    input  logic [WID-1:0]            rom_q_data_in,
    output logic [AW-1:0]             address,
    output logic                      busy,
    output logic                      done,
    output logic                      word_valid,
    output logic [idx_width(DEP)-1:0] word_index,
    output logic [WID-1:0]            word_data,
    output logic [WID-1:0]            rom_data [DEP]
);

    localparam int IW = idx_width(DEP);
    localparam int LW = len_width(DEP);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_burst_reader: RD_LAT out of range");
    end

    rd_state_e     state_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] issue_cnt_q;
    logic [AW-1:0] address_q;
    logic          busy_q;
    logic          done_q;
    logic [LW-1:0] len_d;

    logic          cap_valid;
    logic [IW-1:0] cap_idx;
    logic          cap_pending;

    assign len_d = (burst_len > LW'(DEP)) ? LW'(DEP) : burst_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            address_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    address_q <= '0;
                    if (start) begin
                        len_q       <= len_d;
                        issue_cnt_q <= '0;
                        if (len_d != '0) begin
                            state_q   <= ISSUE;
                            busy_q    <= 1'b1;
                            address_q <= base_addr;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // The address driven during an abort cycle still counts as issued.
                    if (abort || issue_cnt_q == len_q - LW'(1)) begin
                        state_q <= DRAIN;
                    end else begin
                        issue_cnt_q <= issue_cnt_q + LW'(1);
                        address_q   <= address_q + AW'(1);
                    end
                end
                DRAIN: begin
                    if (!cap_pending) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    rd_lat_pipe #(
        .LAT (RD_LAT),
        .IW  (IW)
    ) u_pipe (
        .clk       (clk),
        .clear     (reset),
        .in_valid  (state_q == ISSUE),
        .in_idx    (issue_cnt_q[IW-1:0]),
        .out_valid (cap_valid),
        .out_idx   (cap_idx),
        .pending   (cap_pending)
    );

    // Buffer contents survive reset; a capture landing on the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset && cap_valid) begin
            rom_data[cap_idx] <= rom_q_data_in;
        end
    end

    assign address    = address_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_valid = cap_valid;
    assign word_index = cap_idx;
    assign word_data  = rom_q_data_in;

endmodule

// File: tb/tb_mem_burst_reader.sv
// tb/tb_mem_burst_reader.sv - directed bench for mem_burst_reader at RD_LAT 1 and 2
module tb_mem_burst_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] base_addr = '0;
    logic [5:0] burst_len = '0;

    logic [7:0] q1, q2a, q2;
    logic [8:0] address1, address2;
    logic       busy1, busy2, done1, done2, wv1, wv2;
    logic [4:0] wi1, wi2;
    logic [7:0] wd1, wd2;
    logic [7:0] rd1 [32];
    logic [7:0] rd2 [32];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int e0 = 0;
    bit mon_en = 1'b0;
    int cap1_n, cap2_n, done1_cyc, done2_cyc, addr2_n;
    int cap1_idx [64];
    int cap2_idx [64];
    logic [7:0] cap1_dat [64];
    logic [7:0] cap2_dat [64];
    logic [8:0] addr2_log [64];

    function automatic logic [7:0] fmem(input logic [8:0] a);
        return a[7:0] ^ 8'hA5 ^ {a[8], 7'b0};
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memories with one and two cycles of read latency.
    always @(posedge clk) q1 <= fmem(address1);
    always @(posedge clk) begin
        q2a <= fmem(address2);
        q2  <= q2a;
    end

    mem_burst_reader #(.DEP(32), .WID(8), .AW(9), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .abort(abort), .rom_q_data_in(q1),
        .address(address1), .busy(busy1), .done(done1), .word_valid(wv1),
        .word_index(wi1), .word_data(wd1), .rom_data(rd1)
    );

    mem_burst_reader #(.DEP(32), .WID(8), .AW(9), .RD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .abort(abort), .rom_q_data_in(q2),
        .address(address2), .busy(busy2), .done(done2), .word_valid(wv2),
        .word_index(wi2), .word_data(wd2), .rom_data(rd2)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            if (wv1 && cap1_n < 64) begin
                cap1_idx[cap1_n] = int'(wi1);
                cap1_dat[cap1_n] = wd1;
                cap1_n++;
            end
            if (wv2 && cap2_n < 64) begin
                cap2_idx[cap2_n] = int'(wi2);
                cap2_dat[cap2_n] = wd2;
                cap2_n++;
            end
            if (done1 && done1_cyc == 0) done1_cyc = cyc - e0 + 1;
            if (done2 && done2_cyc == 0) done2_cyc = cyc - e0 + 1;
            if (busy2 && addr2_n < 64) begin
                addr2_log[addr2_n] = address2;
                addr2_n++;
            end
        end
    end

    // Leaves the bench in cycle 1 of the burst, with start sampled at the previous edge.
    task automatic launch(input logic [8:0] b, input logic [5:0] l, input bit hold);
        @(posedge clk); #1;
        mon_en = 1'b0;
        cap1_n = 0; cap2_n = 0; done1_cyc = 0; done2_cyc = 0; addr2_n = 0;
        base_addr = b;
        burst_len = l;
        start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        mon_en = 1'b1;
        if (!hold) start = 1'b0;
        base_addr = ~b;
        burst_len = 6'd1;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while ((done1_cyc == 0 || done2_cyc == 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        n_total++;
        if (done1_cyc == 0 || done2_cyc == 0)
            $display("FAIL %s timeout: done1_cyc=%0d done2_cyc=%0d, required both nonzero", name, done1_cyc, done2_cyc);
        else n_pass++;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_total++; if (busy1 !== 1'b0) $display("FAIL reset busy1 got %b exp 0", busy1); else n_pass++;
        n_total++; if (done1 !== 1'b0) $display("FAIL reset done1 got %b exp 0", done1); else n_pass++;
        n_total++; if (wv1 !== 1'b0) $display("FAIL reset word_valid1 got %b exp 0", wv1); else n_pass++;
        n_total++; if (address1 !== 9'h0) $display("FAIL reset address1 got %h exp 000", address1); else n_pass++;
        n_total++; if (busy2 !== 1'b0) $display("FAIL reset busy2 got %b exp 0", busy2); else n_pass++;
        n_total++; if (done2 !== 1'b0) $display("FAIL reset done2 got %b exp 0", done2); else n_pass++;
        n_total++; if (wv2 !== 1'b0) $display("FAIL reset word_valid2 got %b exp 0", wv2); else n_pass++;
        n_total++; if (wi2 !== 5'd0) $display("FAIL reset word_index2 got %0d exp 0", wi2); else n_pass++;
        n_total++; if (address2 !== 9'h0) $display("FAIL reset address2 got %h exp 000", address2); else n_pass++;
    endtask

    task automatic test_full_burst();
        logic [7:0] e;
        launch(9'h000, 6'd32, 1'b0);
        wait_done("full");
        n_total++; if (cap1_n !== 32) $display("FAIL full captures1 got %0d exp 32", cap1_n); else n_pass++;
        n_total++; if (done1_cyc !== 34) $display("FAIL full done1_cycle got %0d exp 34", done1_cyc); else n_pass++;
        n_total++; if (done2_cyc !== 35) $display("FAIL full done2_cycle got %0d exp 35", done2_cyc); else n_pass++;
        n_total++; if (cap2_n !== 32) $display("FAIL full captures2 got %0d exp 32", cap2_n); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            e = 8'(i) ^ 8'hA5;
            n_total++; if (rd1[i] !== e) $display("FAIL full rom_data1[%0d] got %h exp %h", i, rd1[i], e); else n_pass++;
            n_total++; if (cap1_idx[i] !== i || cap1_dat[i] !== e)
                $display("FAIL full stream1[%0d] got idx %0d data %h exp idx %0d data %h", i, cap1_idx[i], cap1_dat[i], i, e);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [8:0] exp_a [6] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001, 9'h001, 9'h001};
        logic [7:0] exp_d [4] = '{8'hDB, 8'hDA, 8'hA5, 8'hA4};
        launch(9'h1FE, 6'd4, 1'b0);
        wait_done("wrap");
        n_total++; if (addr2_n !== 6) $display("FAIL wrap busy_cycles got %0d exp 6", addr2_n); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++; if (addr2_log[i] !== exp_a[i]) $display("FAIL wrap address[%0d] got %h exp %h", i, addr2_log[i], exp_a[i]); else n_pass++;
        end
        n_total++; if (done2_cyc !== 7) $display("FAIL wrap done2_cycle got %0d exp 7", done2_cyc); else n_pass++;
        n_total++; if (done1_cyc !== 6) $display("FAIL wrap done1_cycle got %0d exp 6", done1_cyc); else n_pass++;
        n_total++; if (cap2_n !== 4) $display("FAIL wrap captures2 got %0d exp 4", cap2_n); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (cap2_idx[i] !== i || cap2_dat[i] !== exp_d[i])
                $display("FAIL wrap stream2[%0d] got idx %0d data %h exp idx %0d data %h", i, cap2_idx[i], cap2_dat[i], i, exp_d[i]);
            else n_pass++;
            n_total++; if (rd2[i] !== exp_d[i]) $display("FAIL wrap rom_data2[%0d] got %h exp %h", i, rd2[i], exp_d[i]); else n_pass++;
        end
        n_total++; if (rd2[4] !== 8'hA1) $display("FAIL wrap rom_data2[4] got %h exp a1", rd2[4]); else n_pass++;
    endtask

    task automatic test_len_zero();
        launch(9'h010, 6'd0, 1'b0);
        wait_done("len0");
        n_total++; if (done1_cyc !== 1) $display("FAIL len0 done1_cycle got %0d exp 1", done1_cyc); else n_pass++;
        n_total++; if (done2_cyc !== 1) $display("FAIL len0 done2_cycle got %0d exp 1", done2_cyc); else n_pass++;
        n_total++; if (cap1_n !== 0 || cap2_n !== 0) $display("FAIL len0 captures got %0d/%0d exp 0/0", cap1_n, cap2_n); else n_pass++;
        n_total++; if (addr2_n !== 0) $display("FAIL len0 busy_cycles got %0d exp 0", addr2_n); else n_pass++;
        n_total++; if (rd2[0] !== 8'hDB) $display("FAIL len0 rom_data2[0] got %h exp db", rd2[0]); else n_pass++;
    endtask

    task automatic test_clamp();
        launch(9'h040, 6'd40, 1'b0);
        wait_done("clamp");
        n_total++; if (cap2_n !== 32) $display("FAIL clamp captures2 got %0d exp 32", cap2_n); else n_pass++;
        n_total++; if (cap1_n !== 32) $display("FAIL clamp captures1 got %0d exp 32", cap1_n); else n_pass++;
        n_total++; if (done2_cyc !== 35) $display("FAIL clamp done2_cycle got %0d exp 35", done2_cyc); else n_pass++;
        n_total++; if (cap2_idx[31] !== 31) $display("FAIL clamp last_index got %0d exp 31", cap2_idx[31]); else n_pass++;
        n_total++; if (rd2[0] !== 8'hE5) $display("FAIL clamp rom_data2[0] got %h exp e5", rd2[0]); else n_pass++;
        n_total++; if (rd2[31] !== 8'hFA) $display("FAIL clamp rom_data2[31] got %h exp fa", rd2[31]); else n_pass++;
    endtask

    task automatic test_abort();
        logic [7:0] exp_d [4] = '{8'h25, 8'h24, 8'h27, 8'hE6};
        launch(9'h100, 6'd32, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done("abort");
        n_total++; if (cap2_n !== 3) $display("FAIL abort captures2 got %0d exp 3", cap2_n); else n_pass++;
        n_total++; if (cap1_n !== 3) $display("FAIL abort captures1 got %0d exp 3", cap1_n); else n_pass++;
        n_total++; if (done2_cyc !== 6) $display("FAIL abort done2_cycle got %0d exp 6", done2_cyc); else n_pass++;
        n_total++; if (done1_cyc !== 5) $display("FAIL abort done1_cycle got %0d exp 5", done1_cyc); else n_pass++;
        n_total++; if (cap2_idx[2] !== 2) $display("FAIL abort last_index got %0d exp 2", cap2_idx[2]); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (rd2[i] !== exp_d[i]) $display("FAIL abort rom_data2[%0d] got %h exp %h", i, rd2[i], exp_d[i]); else n_pass++;
        end
        n_total++; if (rd2[31] !== 8'hFA) $display("FAIL abort rom_data2[31] got %h exp fa", rd2[31]); else n_pass++;
    endtask

    task automatic test_reset_drain();
        logic [7:0] exp_d [4] = '{8'hA5, 8'hA4, 8'h27, 8'hE6};
        launch(9'h000, 6'd4, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        n_total++; if (busy2 !== 1'b1) $display("FAIL rstdrain busy2_before got %b exp 1", busy2); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (busy2 !== 1'b0) $display("FAIL rstdrain busy2 got %b exp 0", busy2); else n_pass++;
        n_total++; if (done2 !== 1'b0) $display("FAIL rstdrain done2 got %b exp 0", done2); else n_pass++;
        n_total++; if (wv2 !== 1'b0) $display("FAIL rstdrain word_valid2 got %b exp 0", wv2); else n_pass++;
        n_total++; if (busy1 !== 1'b0) $display("FAIL rstdrain busy1 got %b exp 0", busy1); else n_pass++;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            n_total++; if (rd2[i] !== exp_d[i]) $display("FAIL rstdrain rom_data2[%0d] got %h exp %h", i, rd2[i], exp_d[i]); else n_pass++;
        end
        launch(9'h020, 6'd4, 1'b0);
        wait_done("rstdrain_restart");
        n_total++; if (done2_cyc !== 7) $display("FAIL rstdrain restart done2_cycle got %0d exp 7", done2_cyc); else n_pass++;
        n_total++; if (rd2[2] !== 8'h87) $display("FAIL rstdrain rom_data2[2] got %h exp 87", rd2[2]); else n_pass++;
        n_total++; if (rd2[3] !== 8'h86) $display("FAIL rstdrain rom_data2[3] got %h exp 86", rd2[3]); else n_pass++;
    endtask

    task automatic test_start_hold();
        logic [7:0] exp_d [3] = '{8'hC5, 8'hC4, 8'hC7};
        launch(9'h030, 6'd2, 1'b1);
        wait_done("hold");
        n_total++; if (done2_cyc !== 5) $display("FAIL hold done2_cycle got %0d exp 5", done2_cyc); else n_pass++;
        n_total++; if (done1_cyc !== 4) $display("FAIL hold done1_cycle got %0d exp 4", done1_cyc); else n_pass++;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_total++; if (done2 !== 1'b1) $display("FAIL hold done2_held got %b exp 1", done2); else n_pass++;
        n_total++; if (busy2 !== 1'b0) $display("FAIL hold busy2_held got %b exp 0", busy2); else n_pass++;
        n_total++; if (cap2_n !== 2) $display("FAIL hold captures2 got %0d exp 2", cap2_n); else n_pass++;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (done2 !== 1'b0) $display("FAIL hold done2_release got %b exp 0", done2); else n_pass++;
        launch(9'h060, 6'd3, 1'b0);
        wait_done("hold_second");
        n_total++; if (done2_cyc !== 6) $display("FAIL hold second done2_cycle got %0d exp 6", done2_cyc); else n_pass++;
        n_total++; if (cap2_n !== 3) $display("FAIL hold second captures2 got %0d exp 3", cap2_n); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (rd2[i] !== exp_d[i]) $display("FAIL hold rom_data2[%0d] got %h exp %h", i, rd2[i], exp_d[i]); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_burst();
        test_wrap();
        test_len_zero();
        test_clamp();
        test_abort();
        test_reset_drain();
        test_start_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
